// File: rtl/prime_pair_gen_pkg.sv
// -----------------------------------------------------------------------------
// prime_pair_gen_pkg
// Shared definitions for the prime-pair generator: controller state encoding,
// default candidate width, default checker timeout and the largest candidate
// value at the default width.
// -----------------------------------------------------------------------------
package prime_pair_gen_pkg;

  localparam int W_DEF       = 8;
  localparam int TIMEOUT_DEF = 1024;

  // Largest candidate representable at the default width (2^W_DEF - 1).
  localparam logic [W_DEF-1:0] CAND_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    FAIL
  } state_t;

endpackage

// File: rtl/chk_watchdog.sv
// -----------------------------------------------------------------------------
// chk_watchdog
// Cycle counter that bounds how long the controller waits for the external
// prime checker.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (count := 0)
//   clear    in   restart the count at zero
//   enable   in   advance the count by one this cycle
//   expired  out  count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module chk_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // The count saturates at LAST so a caller that keeps enable high past
  // expiry still sees expired rather than a wrapped count.
  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  // Pure function of the count; the controller decides when it matters.
  assign expired = (count == LAST);

endmodule

// File: rtl/prime_pair_gen.sv
// -----------------------------------------------------------------------------
// prime_pair_gen
// Walks odd candidates upward from a seed, handing each one to an external
// prime checker, and reports the first two primes found.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   start         in   one-cycle run request, honoured only while idle
//   seed   [W]    in   lowest candidate to consider, sampled with start
//   chk_start     out  one-cycle start pulse to the checker
//   chk_num [W]   out  candidate under test, stable until chk_finish
//   chk_finish    in   checker result strobe
//   chk_is_prime  in   checker verdict, qualified by chk_finish
//   busy          out  a run is in progress
//   p, q   [W]    out  first and second primes of the last run
//   done          out  one-cycle pulse: pair found
//   fail          out  one-cycle pulse: candidates exhausted or checker timeout
// -----------------------------------------------------------------------------
module prime_pair_gen
  import prime_pair_gen_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int W       = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] seed,
  output logic         chk_start,
  output logic [W-1:0] chk_num,
  input  logic         chk_finish,
  input  logic         chk_is_prime,
  output logic         busy,
  output logic [W-1:0] p,
  output logic [W-1:0] q,
  output logic         done,
  output logic         fail
);

  localparam logic [W-1:0] CAND_LAST = {W{1'b1}};
  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [W-1:0] TWO       = W'(2);
  localparam logic [W-1:0] THREE     = W'(3);

  state_t       state, state_next;
  logic [W-1:0] cand, cand_next;
  logic [W-1:0] p_next, q_next;
  logic [W-1:0] seed_odd;
  logic         found, found_next;
  logic         wd_clear, wd_enable, wd_expired;

  chk_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  assign seed_odd = seed | ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cand  <= '0;
      found <= 1'b0;
      p     <= '0;
      q     <= '0;
    end else begin
      state <= state_next;
      cand  <= cand_next;
      found <= found_next;
      p     <= p_next;
      q     <= q_next;
    end
  end

  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_next = state;
    cand_next  = cand;
    found_next = found;
    p_next     = p;
    q_next     = q;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          // 1 is not prime and 2 is never odd, so the search floor is 3.
          cand_next  = (seed_odd == ONE) ? THREE : seed_odd;
          found_next = 1'b0;
          p_next     = '0;
          q_next     = '0;
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        wd_clear   = 1'b1;
        state_next = WAIT;
      end

      WAIT: begin
        wd_enable = 1'b1;
        if (chk_finish) begin
          if (chk_is_prime && found) begin
            q_next     = cand;
            state_next = DONE;
          end else begin
            if (chk_is_prime) begin
              p_next     = cand;
              found_next = 1'b1;
            end
            // Candidates are odd, so the all-ones value is the last one
            // reachable without wrapping.
            if (cand == CAND_LAST) begin
              state_next = FAIL;
            end else begin
              cand_next  = cand + TWO;
              state_next = ISSUE;
            end
          end
        end else if (wd_expired) begin
          state_next = FAIL;
        end
      end

      DONE, FAIL: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign chk_start = (state == ISSUE);
  assign chk_num   = cand;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign fail      = (state == FAIL);

endmodule

// File: tb/tb_prime_pair_gen.sv
// -----------------------------------------------------------------------------
// tb_prime_pair_gen
// Bench for prime_pair_gen with a behavioural prime checker (random latency,
// optional silence) and a run-level reference model. The model precomputes the
// candidate list and the resulting pair for each run from the seed, then a
// per-cycle compare process sequences through it using the checker's response
// times.
// -----------------------------------------------------------------------------
module tb_prime_pair_gen;
  import prime_pair_gen_pkg::*;

  localparam int W    = W_DEF;
  localparam int TO   = 16;
  localparam int CMAX = int'(CAND_MAX);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] seed = '0;
  logic         chk_finish = 1'b0;
  logic         chk_is_prime = 1'b0;
  logic         chk_start, busy, done, fail;
  logic [W-1:0] chk_num, p, q;

  prime_pair_gen #(
    .TIMEOUT (TO),
    .W       (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .seed         (seed),
    .chk_start    (chk_start),
    .chk_num      (chk_num),
    .chk_finish   (chk_finish),
    .chk_is_prime (chk_is_prime),
    .busy         (busy),
    .p            (p),
    .q            (q),
    .done         (done),
    .fail         (fail)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic start_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) start_q <= start;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Run plan: what the next accepted start must produce.
  // ---------------------------------------------------------------------------
  int run_cands[$];
  int run_p, run_q;
  bit run_ok;
  bit mute = 1'b0;
  int lat_force = 0;
  int fin_cyc = -10;

  task automatic plan_run(input int s);
    int c;
    bit have_p;
    run_cands.delete();
    run_p  = 0;
    run_q  = 0;
    run_ok = 1'b0;
    have_p = 1'b0;
    c = s | 1;
    if (c == 1) c = 3;
    if (mute) begin
      run_cands.push_back(c);
      return;
    end
    forever begin
      run_cands.push_back(c);
      if (is_prime(c)) begin
        if (have_p) begin
          run_q  = c;
          run_ok = 1'b1;
          break;
        end
        run_p  = c;
        have_p = 1'b1;
      end
      if (c == CMAX) break;
      c += 2;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural prime checker: answers each chk_start after 1..12 cycles
  // (or lat_force cycles), or never when muted. Verdict junk outside finish.
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_start && !rst && !mute) begin
        int lat;
        int num;
        num = int'(chk_num);
        lat = (lat_force > 0) ? lat_force : int'($urandom_range(1, 12));
        repeat (lat) @(posedge clk);
        #1;
        chk_finish   = 1'b1;
        chk_is_prime = is_prime(num);
        fin_cyc      = cyc;
        @(posedge clk);
        #1;
        chk_finish   = 1'b0;
        chk_is_prime = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the run model.
  // ---------------------------------------------------------------------------
  bit m_busy = 1'b0, m_wait = 1'b0, m_ok = 1'b0, m_mute = 1'b0;
  int m_issue = -1, m_end = -1, m_idx = 0;
  int m_p = 0, m_q = 0, m_run_p = 0, m_run_q = 0;
  int m_cands[$];
  bit prev_busy, exp_start, exp_end;
  int done_cnt = 0, fail_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_wait  = 1'b0;
      m_issue = -1;
      m_end   = -1;
      m_p     = 0;
      m_q     = 0;
      check("rst_busy", busy, 0);
      check("rst_chk_start", chk_start, 0);
      check("rst_done", done, 0);
      check("rst_fail", fail, 0);
      check("rst_chk_num", chk_num, 0);
      check("rst_p", p, 0);
      check("rst_q", q, 0);
    end else begin
      prev_busy = m_busy;
      if (prev_busy && m_end >= 0 && cyc == m_end + 1) begin
        m_busy = 1'b0;
        m_wait = 1'b0;
        m_p    = m_run_p;
        m_q    = m_run_q;
      end
      if (!prev_busy && start_q) begin
        m_busy    = 1'b1;
        m_issue   = cyc;
        m_end     = -1;
        m_wait    = 1'b0;
        m_idx     = 0;
        m_cands   = run_cands;
        m_run_p   = run_p;
        m_run_q   = run_q;
        m_ok      = run_ok;
        m_mute    = mute;
      end
      if (m_busy && m_wait && fin_cyc == cyc - 1) begin
        m_wait = 1'b0;
        m_idx++;
        if (m_idx >= m_cands.size()) m_end = cyc;
        else m_issue = cyc;
      end
      exp_start = m_busy && (cyc == m_issue);
      exp_end   = m_busy && (cyc == m_end);
      check("busy", busy, m_busy);
      check("chk_start", chk_start, exp_start);
      check("done", done, exp_end && m_ok);
      check("fail", fail, exp_end && !m_ok);
      if (exp_start || m_wait) check("chk_num", chk_num, m_cands[m_idx]);
      if (exp_end) begin
        check("p_final", p, m_run_p);
        check("q_final", q, m_run_q);
      end
      if (!m_busy) begin
        check("p_hold", p, m_p);
        check("q_hold", q, m_q);
      end
      if (exp_start) begin
        m_wait  = 1'b1;
        m_issue = -1;
        if (m_mute) m_end = cyc + 1 + TO;
      end
    end
    if (done) done_cnt++;
    if (fail) fail_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic pulse_start(input int s);
    @(posedge clk); #1;
    seed  = W'(s);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seed  = W'($urandom);
  endtask

  task automatic launch(input int s);
    plan_run(s);
    pulse_start(s);
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(done || fail) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_end_seen"}, done || fail, 1);
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  int d0, f0, t0;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_pq", {p, q}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // seed 7 -> 7, 11
    d0 = done_cnt; f0 = fail_cnt;
    launch(7);
    wait_end("seed7");
    check("seed7_p", p, 7);
    check("seed7_q", q, 11);
    check("seed7_done_pulses", done_cnt - d0, 1);
    check("seed7_fail_pulses", fail_cnt - f0, 0);

    // seed 0 -> first candidate 3, pair 3, 5
    launch(0);
    check("seed0_first_num", chk_num, 3);
    check("seed0_first_start", chk_start, 1);
    wait_end("seed0");
    check("seed0_p", p, 3);
    check("seed0_q", q, 5);

    // seed 250 -> 251 found, 253/255 rejected, range exhausted
    d0 = done_cnt; f0 = fail_cnt;
    launch(250);
    wait_end("seed250");
    check("seed250_p", p, 251);
    check("seed250_q", q, 0);
    check("seed250_fail_pulses", fail_cnt - f0, 1);
    check("seed250_done_pulses", done_cnt - d0, 0);

    // silent checker -> timeout
    mute = 1'b1;
    launch(9);
    t0 = cyc;
    for (int n = 0; n < 100 && !fail; n++) begin
      @(posedge clk); #1;
    end
    check("timeout_fail_seen", fail, 1);
    check("timeout_latency", cyc - t0, TO + 1);
    @(posedge clk); #1;
    check("timeout_busy_drop", busy, 0);
    mute = 1'b0;
    repeat (2) @(posedge clk);

    // start re-pulsed mid-run is ignored
    lat_force = 8;
    d0 = done_cnt;
    launch(7);
    repeat (3) begin
      @(posedge clk); #1;
    end
    pulse_start(100);
    lat_force = 0;
    wait_end("restart");
    check("restart_p", p, 7);
    check("restart_q", q, 11);
    check("restart_done_pulses", done_cnt - d0, 1);

    // reset mid-WAIT, stale chk_finish afterwards
    lat_force = 10;
    d0 = done_cnt; f0 = fail_cnt;
    launch(7);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    lat_force = 0;
    check("midrst_busy", busy, 0);
    check("midrst_p", p, 0);
    check("midrst_q", q, 0);
    check("midrst_pulses", (done_cnt - d0) + (fail_cnt - f0), 0);
    launch(7);
    wait_end("after_rst");
    check("after_rst_p", p, 7);
    check("after_rst_q", q, 11);

    // randomized seeds
    for (int i = 0; i < 40; i++) begin
      launch(int'($urandom_range(0, CMAX)));
      wait_end("random");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
